secded_mem_sequencer: RTL and testbench

//   Hardware sequencer for the SECDED (Hamming 15,11 + overall parity) decode task.
//   On start, it walks NUM_WORDS 16-bit code words in data memory, at SRC_BASE little-endian byte pairs.
//   It decodes and corrects each word, and writes a 16-bit result pair to DST_BASE.
//   It drives the data-memory port of top_level in place of the program loop and signals done.

---
 rtl/secded_mem_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_secded_mem_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/secded_mem_sequencer.sv
// secded_mem_sequencer
//   Walks NUM_WORDS 16-bit SECDED (Hamming 15,11 + overall parity) code words
//   stored as little-endian byte pairs at SRC_BASE. Each word is decoded and
//   corrected, and a 16-bit result {F[1:0], 3'b000, d11..d1} is written as a
//   byte pair at DST_BASE. The run takes 5 cycles per word, and done is raised
//   at the end.
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin a run (honoured only in IDLE or DONE)
//   busy, done          run in progress / run finished (level)
//   mem_addr            byte address; mem_rd_data is returned in the same cycle
//   mem_rd_data         read data for mem_addr
//   mem_wr_en           write strobe (memory writes on the clock edge)
//   mem_wr_data         write data
//   single_cnt          corrected words this run (saturating)
//   double_cnt          uncorrectable words this run (saturating)
module secded_mem_sequencer #(
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [7:0]    single_cnt,
  output logic [7:0]    double_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    DECODE = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam int            IW        = (NUM_WORDS < 2) ? 1 : $clog2(NUM_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] SRC_ADDR  = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_ADDR  = AW'(DST_BASE);
  localparam bit            NO_WORDS  = (NUM_WORDS == 0);

  // Decode one code word into {F[1:0], 3'b000, d11..d1}.
  function automatic logic [15:0] secded_decode(input logic [15:0] c);
    logic [3:0]  syn;
    logic        par;
    logic [15:0] fixed;
    logic [1:0]  flag;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (c[k]) begin
        syn = syn ^ 4'(k);
      end else begin
        syn = syn;
      end
    end
    par = ^c;
    if (par) begin
      // Odd overall parity: a single flip at position syn (syn==0 means p0).
      fixed = c ^ (16'h0001 << syn);
      flag  = 2'b01;
    end else if (syn != 4'd0) begin
      fixed = c;
      flag  = 2'b10;
    end else begin
      fixed = c;
      flag  = 2'b00;
    end
    return {flag, 3'b000, fixed[15:9], fixed[7:5], fixed[3]};
  endfunction

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   idx_r, idx_nxt_s;
  logic            start_run_s;
  logic [15:0]     code_r;
  logic [15:0]     res_r;
  logic [15:0]     dec_s;
  logic [AW-1:0]   mem_addr_r, addr_nxt_s;
  logic [AW-1:0]   src_addr_s, dst_addr_s;
  logic            mem_wr_en_r, we_nxt_s;
  logic [7:0]      mem_wr_data_r, wdata_nxt_s;
  logic            busy_r, busy_nxt_s;
  logic            done_r;
  logic [7:0]      single_cnt_r, double_cnt_r;

  assign dec_s = secded_decode(code_r);

  // Next state and next word index.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    start_run_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          start_run_s = 1'b1;
          idx_nxt_s   = {IW{1'b0}};
          state_nxt_s = NO_WORDS ? DONE : RD_LO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RD_LO:  state_nxt_s = RD_HI;
      RD_HI:  state_nxt_s = DECODE;
      DECODE: state_nxt_s = WR_LO;
      WR_LO:  state_nxt_s = WR_HI;
      WR_HI: begin
        idx_nxt_s = idx_r + IDX_ONE;
        if (idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RD_LO;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory-port values for the state being entered, so the port is registered.
  always_comb begin
    src_addr_s  = SRC_ADDR + (AW'(idx_nxt_s) << 1'b1);
    dst_addr_s  = DST_ADDR + (AW'(idx_nxt_s) << 1'b1);
    addr_nxt_s  = {AW{1'b0}};
    we_nxt_s    = 1'b0;
    wdata_nxt_s = 8'h00;
    busy_nxt_s  = 1'b0;
    case (state_nxt_s)
      RD_LO: begin
        addr_nxt_s = src_addr_s;
        busy_nxt_s = 1'b1;
      end
      RD_HI: begin
        addr_nxt_s = src_addr_s + ADDR_ONE;
        busy_nxt_s = 1'b1;
      end
      DECODE: begin
        busy_nxt_s = 1'b1;
      end
      WR_LO: begin
        // Entered from DECODE, where res_r is not yet loaded.
        addr_nxt_s  = dst_addr_s;
        we_nxt_s    = 1'b1;
        wdata_nxt_s = dec_s[7:0];
        busy_nxt_s  = 1'b1;
      end
      WR_HI: begin
        addr_nxt_s  = dst_addr_s + ADDR_ONE;
        we_nxt_s    = 1'b1;
        wdata_nxt_s = res_r[15:8];
        busy_nxt_s  = 1'b1;
      end
      default: begin
        addr_nxt_s = {AW{1'b0}};
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= {IW{1'b0}};
      code_r        <= 16'h0000;
      res_r         <= 16'h0000;
      mem_addr_r    <= {AW{1'b0}};
      mem_wr_en_r   <= 1'b0;
      mem_wr_data_r <= 8'h00;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      single_cnt_r  <= 8'h00;
      double_cnt_r  <= 8'h00;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      mem_addr_r    <= addr_nxt_s;
      mem_wr_en_r   <= we_nxt_s;
      mem_wr_data_r <= wdata_nxt_s;
      busy_r        <= busy_nxt_s;
      // A start seen in DONE drops done on the very next cycle.
      done_r        <= (state_r == DONE) && !start;
      case (state_r)
        RD_LO:   code_r[7:0]  <= mem_rd_data;
        RD_HI:   code_r[15:8] <= mem_rd_data;
        DECODE:  res_r        <= dec_s;
        default: res_r        <= res_r;
      endcase
      if (start_run_s) begin
        single_cnt_r <= 8'h00;
        double_cnt_r <= 8'h00;
      end else if (state_r == DECODE) begin
        if (dec_s[14] && (single_cnt_r != 8'hFF)) begin
          single_cnt_r <= single_cnt_r + 8'h01;
        end else begin
          single_cnt_r <= single_cnt_r;
        end
        if (dec_s[15] && (double_cnt_r != 8'hFF)) begin
          double_cnt_r <= double_cnt_r + 8'h01;
        end else begin
          double_cnt_r <= double_cnt_r;
        end
      end else begin
        single_cnt_r <= single_cnt_r;
        double_cnt_r <= double_cnt_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wr_en   = mem_wr_en_r;
  assign mem_wr_data = mem_wr_data_r;
  assign single_cnt  = single_cnt_r;
  assign double_cnt  = double_cnt_r;

endmodule

// File: tb/tb_secded_mem_sequencer.sv
// Testbench for secded_mem_sequencer: randomized code words (with injected
// 0/1/2-bit errors) checked by a write scoreboard against a reference model.
module tb_secded_mem_sequencer;

  localparam int N   = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] single_cnt;
  logic [7:0] double_cnt;

  logic [7:0] mem [0:255];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          exp_single;
  int          exp_double;
  logic [15:0] exp_res [0:N-1];

  always #5 clk = ~clk;

  secded_mem_sequencer #(
    .SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(N), .AW(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is compared with the next expected one.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", {24'd0, mem_wr_data}, {24'd0, e.data});
      end
    end
  end

  // Data bit d(j+1) sits at code position DPOS[j].
  int DPOS [0:10] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w = 16'h0000;
    int syn = 0;
    for (int j = 0; j < 11; j++) begin
      w[DPOS[j]] = d[j];
      if (d[j]) syn = syn ^ DPOS[j];
    end
    w[1] = syn[0]; w[2] = syn[1]; w[4] = syn[2]; w[8] = syn[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

  // Reference decode: kind 0 = clean, 1 = corrected, 2 = uncorrectable.
  function automatic logic [15:0] ref_decode(input logic [15:0] c, output int kind);
    int syn = 0;
    int ones = 0;
    logic [15:0] w = c;
    logic [10:0] d;
    for (int k = 0; k < 16; k++) begin
      if (c[k]) begin
        ones++;
        syn = syn ^ k;
      end
    end
    if (ones % 2 == 1) begin
      kind = 1;
      w[syn] = ~w[syn];
    end else if (syn != 0) kind = 2;
    else kind = 0;
    for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
    return {kind[1:0] == 2'd2 ? 2'b10 : (kind == 1 ? 2'b01 : 2'b00), 3'b000, d};
  endfunction

  // Fill the source area and queue the expected result writes.
  task automatic prepare(input bit directed);
    logic [15:0] tbl [0:3] = '{16'h0000, 16'h0008, 16'h0001, 16'h0006};
    logic [15:0] w;
    logic [7:0]  a;
    int kind, nerr, p1, p2;
    exp_single = 0;
    exp_double = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (directed && i < 4) w = tbl[i];
      else begin
        w = encode(11'($urandom));
        nerr = $urandom_range(0, 2);
        p1 = $urandom_range(0, 15);
        p2 = (p1 + $urandom_range(1, 15)) % 16;
        if (nerr >= 1) w[p1] = ~w[p1];
        if (nerr == 2) w[p2] = ~w[p2];
      end
      a = 8'(SRC + 2 * i);
      mem[a] = w[7:0];
      a = a + 8'd1;
      mem[a] = w[15:8];
      exp_res[i] = ref_decode(w, kind);
      if (kind == 1) exp_single++;
      if (kind == 2) exp_double++;
      exp_q.push_back('{addr: 8'(DST + 2 * i),     data: exp_res[i][7:0]});
      exp_q.push_back('{addr: 8'(DST + 2 * i + 1), data: exp_res[i][15:8]});
    end
  endtask

  // Pulse start so it is sampled at the next rising edge (edge 0).
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done (bounded), optionally pulsing start while busy, then check.
  task automatic finish_run(input bit pulse_mid);
    int cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      start = (pulse_mid && cycles == 30) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check("done_latency", cycles, 76);
    @(negedge clk);
    check("write_count", wr_count, 2 * N);
    check("queue_empty", exp_q.size(), 0);
    check("single_cnt", {24'd0, single_cnt}, exp_single);
    check("double_cnt", {24'd0, double_cnt}, exp_double);
    check("busy_at_done", {31'd0, busy}, 0);
    for (int i = 0; i < N; i++) begin
      check("mem_result", {16'd0, mem[8'(DST + 2 * i + 1)], mem[8'(DST + 2 * i)]}, {16'd0, exp_res[i]});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_we", {31'd0, mem_wr_en}, 0);
    check("rst_addr", {24'd0, mem_addr}, 0);
    check("rst_single", {24'd0, single_cnt}, 0);
    check("rst_double", {24'd0, double_cnt}, 0);
    @(posedge clk); #1;

    // Run 1: directed vectors in words 0..3, random rest, extra start while busy.
    prepare(1'b1);
    wr_count = 0;
    do_start();
    check("busy_after_start", {31'd0, busy}, 1);
    finish_run(1'b1);
    check("result_clean", {16'd0, exp_res[0]}, 32'h0000);
    check("result_d1", {16'd0, exp_res[1]}, 32'h4000);
    check("result_p0", {16'd0, exp_res[2]}, 32'h4000);
    check("result_double", {16'd0, exp_res[3]}, 32'h8000);

    // done holds and counts hold until the next start.
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", {31'd0, done}, 1);
    check("single_hold", {24'd0, single_cnt}, exp_single);
    check("double_hold", {24'd0, double_cnt}, exp_double);

    // Run 2: start from DONE, then reset at cycle 20 of the run.
    prepare(1'b0);
    wr_count = 0;
    do_start();
    check("done_drop", {31'd0, done}, 0);
    check("busy_run2", {31'd0, busy}, 1);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_we", {31'd0, mem_wr_en}, 0);
    check("midrst_single", {24'd0, single_cnt}, 0);
    check("midrst_double", {24'd0, double_cnt}, 0);
    repeat (5) @(posedge clk);
    #1;
    check("idle_after_rst", {31'd0, busy}, 0);

    // Run 3: fresh run from IDLE after the abandoned one.
    prepare(1'b0);
    wr_count = 0;
    do_start();
    finish_run(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
